// File: rtl/game_cmd_pkg.sv
// Shared command codes, scheduler state encoding and key bit positions
// for the 2048 key-to-command path.
package game_cmd_pkg;

    typedef logic [2:0] cmd_code_t;

    localparam cmd_code_t CMD_UP      = 3'd0;
    localparam cmd_code_t CMD_DOWN    = 3'd1;
    localparam cmd_code_t CMD_LEFT    = 3'd2;
    localparam cmd_code_t CMD_RIGHT   = 3'd3;
    localparam cmd_code_t CMD_RESTART = 3'd4;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COOLDOWN
    } state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_cmd_scheduler_if.sv
// Valid/ready command channel from the key scheduler to the game engine.
interface key_cmd_scheduler_if;
    import game_cmd_pkg::*;

    logic      cmd_valid;
    cmd_code_t cmd_code;
    logic      cmd_ready;

    modport master (output cmd_valid, output cmd_code, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/key_cmd_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: grants the first request found
// searching upward (mod 4) from ptr. The pointer register lives in the parent.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic       valid
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant = 4'b0000;
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] idx;
            idx = ptr + 2'(i);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Turns key press pulses, held levels and restart into an ordered command
// stream: round-robin arbitration, one pending slot, cooldown and auto-repeat.
module key_cmd_scheduler
    import game_cmd_pkg::*;
#(
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int CNT_W           = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            key_pos,
    input  logic [3:0]            key_level,
    input  logic                  restart_pos,
    key_cmd_scheduler_if.master   cmd,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);

    localparam bit NO_COOLDOWN = (COOLDOWN_CYCLES == 0);

    state_t            state, state_d;
    logic              valid_q, valid_d;
    cmd_code_t         code_q, code_d;
    logic              pend_full, pend_full_d;
    cmd_code_t         pend_code, pend_code_d;
    logic [CNT_W-1:0]  cool_cnt, cool_d;
    logic [1:0]        rr_ptr;
    logic              rep_active;
    logic [1:0]        rep_dir;
    logic [CNT_W-1:0]  rep_cnt;

    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       held, rep_fire;
    logic       ev_valid, dir_grant;
    cmd_code_t  ev_code;
    logic       accept, rule_now, issue_load, drop_inc;

    rr_arbiter4 u_arb (
        .req   (key_pos),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    assign grant_idx = onehot_to_idx(grant);
    // The timer only runs while the repeat key is the sole key held down.
    assign held      = rep_active && (key_level == (4'b0001 << rep_dir));
    assign rep_fire  = held && (rep_cnt == CNT_W'(1));

    always_comb begin
        ev_valid  = 1'b1;
        ev_code   = CMD_RESTART;
        dir_grant = 1'b0;
        if (restart_pos) begin
            ev_code = CMD_RESTART;
        end else if (grant_valid) begin
            ev_code   = {1'b0, grant_idx};
            dir_grant = 1'b1;
        end else if (rep_fire) begin
            ev_code = {1'b0, rep_dir};
        end else begin
            ev_valid = 1'b0;
        end
    end

    assign accept   = (state == ISSUE) && valid_q && cmd.cmd_ready;
    assign rule_now = (accept && NO_COOLDOWN) ||
                      ((state == COOLDOWN) && (cool_cnt == CNT_W'(1)));

    always_comb begin
        state_d     = state;
        valid_d     = valid_q;
        code_d      = code_q;
        pend_full_d = pend_full;
        pend_code_d = pend_code;
        cool_d      = cool_cnt;
        issue_load  = 1'b0;
        drop_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (ev_valid) begin
                    state_d    = ISSUE;
                    valid_d    = 1'b1;
                    code_d     = ev_code;
                    issue_load = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    valid_d = 1'b0;
                    if (!NO_COOLDOWN) begin
                        state_d = COOLDOWN;
                        cool_d  = CNT_W'(COOLDOWN_CYCLES);
                    end
                end
                if (state == COOLDOWN) cool_d = cool_cnt - CNT_W'(1);
                if (rule_now) begin
                    // Pending entry leaves first; a same-cycle event takes the freed slot.
                    if (pend_full) begin
                        state_d     = ISSUE;
                        valid_d     = 1'b1;
                        code_d      = pend_code;
                        issue_load  = 1'b1;
                        pend_full_d = ev_valid;
                        pend_code_d = ev_code;
                    end else if (ev_valid) begin
                        state_d    = ISSUE;
                        valid_d    = 1'b1;
                        code_d     = ev_code;
                        issue_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ev_valid) begin
                    if (!pend_full) begin
                        pend_full_d = 1'b1;
                        pend_code_d = ev_code;
                    end else if (ev_code == CMD_RESTART) begin
                        pend_code_d = CMD_RESTART;
                        drop_inc    = (pend_code != CMD_RESTART);
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            code_q     <= CMD_UP;
            pend_full  <= 1'b0;
            pend_code  <= CMD_UP;
            cool_cnt   <= '0;
            rr_ptr     <= 2'd0;
            rep_active <= 1'b0;
            rep_dir    <= 2'd0;
            rep_cnt    <= '0;
            drop_cnt   <= 8'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state     <= state_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            pend_full <= pend_full_d;
            pend_code <= pend_code_d;
            cool_cnt  <= cool_d;
            if (dir_grant) rr_ptr <= grant_idx + 2'd1;
            if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

            if (dir_grant) begin
                rep_active <= 1'b1;
                rep_dir    <= grant_idx;
                rep_cnt    <= CNT_W'(HOLD_CYCLES);
            end else if (issue_load && code_d == CMD_RESTART) begin
                rep_active <= 1'b0;
            end else if (held) begin
                rep_cnt <= rep_fire ? CNT_W'(REPEAT_CYCLES) : rep_cnt - CNT_W'(1);
            end else begin
                rep_active <= 1'b0;
            end
        end
    end

    assign cmd.cmd_valid = valid_q;
    assign cmd.cmd_code  = code_q;
    assign busy          = (state != IDLE) || pend_full;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler with short hold/repeat timers;
// inputs change and outputs are sampled on the falling clock edge.
module tb_key_cmd_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key_pos = 4'b0000;
    logic [3:0] key_level = 4'b0000;
    logic       restart_pos = 1'b0;
    logic       busy;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    key_cmd_scheduler_if cmd_bus ();

    key_cmd_scheduler #(
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (5),
        .COOLDOWN_CYCLES (4),
        .CNT_W           (25)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_pos     (key_pos),
        .key_level   (key_level),
        .restart_pos (restart_pos),
        .cmd         (cmd_bus.master),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        key_pos = k;
        tick();
        key_pos = 4'b0000;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        key_pos     = 4'b0000;
        key_level   = 4'b0000;
        restart_pos = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && (busy || cmd_bus.cmd_valid); i++) tick();
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_bus.cmd_ready = 1'b1;
        do_reset();

        // Reset state
        check("rst_valid", cmd_bus.cmd_valid, 0);
        check("rst_code", cmd_bus.cmd_code, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);

        // Single left press, 1-cycle latency then 4 cooldown cycles
        press(4'b0100);
        check("left_valid", cmd_bus.cmd_valid, 1);
        check("left_code", cmd_bus.cmd_code, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("cool_valid_%0d", i), cmd_bus.cmd_valid, 0);
            check($sformatf("cool_busy_%0d", i), busy, 1);
        end
        tick();
        check("cool_done_busy", busy, 0);

        // Round robin from rr_ptr=0 with all four keys pressed
        do_reset();
        for (int r = 0; r < 3; r++) begin
            press(4'b1111);
            check($sformatf("rr_valid_%0d", r), cmd_bus.cmd_valid, 1);
            check($sformatf("rr_code_%0d", r), cmd_bus.cmd_code, r);
            wait_idle("rr");
        end

        // Blocked engine: up issued, down pending, left dropped
        cmd_bus.cmd_ready = 1'b0;
        press(4'b0001);
        check("blk_code0", cmd_bus.cmd_code, 0);
        press(4'b0010);
        check("blk_code1", cmd_bus.cmd_code, 0);
        press(4'b0100);
        check("blk_code2", cmd_bus.cmd_code, 0);
        check("blk_valid", cmd_bus.cmd_valid, 1);
        check("blk_drop", drop_cnt, 1);
        cmd_bus.cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("blk_gap_%0d", i), cmd_bus.cmd_valid, 0);
        end
        tick();
        check("pend_valid", cmd_bus.cmd_valid, 1);
        check("pend_code", cmd_bus.cmd_code, 1);
        wait_idle("pend");
        check("pend_drop", drop_cnt, 1);

        // Restart overwrites a pending direction and counts it as a drop
        cmd_bus.cmd_ready = 1'b0;
        press(4'b1000);
        check("ovr_code0", cmd_bus.cmd_code, 3);
        press(4'b0010);
        restart_pos = 1'b1;
        tick();
        restart_pos = 1'b0;
        check("ovr_code1", cmd_bus.cmd_code, 3);
        check("ovr_drop", drop_cnt, 2);
        cmd_bus.cmd_ready = 1'b1;
        repeat (4) tick();
        check("ovr_gap", cmd_bus.cmd_valid, 0);
        tick();
        check("ovr_valid", cmd_bus.cmd_valid, 1);
        check("ovr_restart", cmd_bus.cmd_code, 4);
        wait_idle("ovr");

        // Auto-repeat: hold right, commands at grant+1, +11, +16, +21, +26
        key_pos   = 4'b1000;
        key_level = 4'b1000;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) key_pos = 4'b0000;
            check($sformatf("rep_valid_%0d", k), cmd_bus.cmd_valid,
                  (k == 1 || k == 11 || k == 16 || k == 21 || k == 26) ? 1 : 0);
            if (cmd_bus.cmd_valid) check($sformatf("rep_code_%0d", k), cmd_bus.cmd_code, 3);
        end
        // A second key is pressed: one up command, then no more repeats
        key_pos   = 4'b0001;
        key_level = 4'b1001;
        tick();
        key_pos = 4'b0000;
        check("stop_valid", cmd_bus.cmd_valid, 1);
        check("stop_code", cmd_bus.cmd_code, 0);
        begin
            int extra;
            extra = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (cmd_bus.cmd_valid) extra++;
            end
            check("stop_extra", extra, 0);
        end
        key_level = 4'b0000;
        wait_idle("stop");

        // Asynchronous reset while issuing with a full pending slot
        cmd_bus.cmd_ready = 1'b0;
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        check("pre_rst_valid", cmd_bus.cmd_valid, 1);
        check("pre_rst_drop", drop_cnt, 3);
        reset = 1'b0;
        #1;
        check("arst_valid", cmd_bus.cmd_valid, 0);
        check("arst_code", cmd_bus.cmd_code, 0);
        check("arst_busy", busy, 0);
        check("arst_drop", drop_cnt, 0);
        tick();
        reset = 1'b1;
        cmd_bus.cmd_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            check($sformatf("post_rst_valid_%0d", k), cmd_bus.cmd_valid, 0);
        end

        // Restart beats a same-cycle direction and leaves rr_ptr alone
        restart_pos = 1'b1;
        key_pos     = 4'b0010;
        tick();
        restart_pos = 1'b0;
        key_pos     = 4'b0000;
        check("prio_valid", cmd_bus.cmd_valid, 1);
        check("prio_code", cmd_bus.cmd_code, 4);
        wait_idle("prio");
        press(4'b1111);
        check("prio_rr_code", cmd_bus.cmd_code, 0);
        wait_idle("prio_rr");

        // drop_cnt saturates at 255
        cmd_bus.cmd_ready = 1'b0;
        press(4'b0001);
        press(4'b0010);
        for (int k = 0; k < 260; k++) press(4'b0100);
        check("sat_drop", drop_cnt, 255);
        cmd_bus.cmd_ready = 1'b1;
        wait_idle("sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_cmd_scheduler.md
# key_cmd_scheduler

Converts the edge-detected button events of the 2048 board into a single ordered stream of game commands for the game engine. Four direction keys and a restart key arrive as one-cycle press pulses plus debounced levels from the key front end. The block does the following:
- arbitrates simultaneous presses round-robin;
- buffers one command while the engine is busy;
- enforces a post-move cooldown;
- generates auto-repeat moves while a direction key is held.

## Interface
- HOLD_CYCLES, 25_000_000: cycles a direction key must stay held before the first auto-repeat (0.5 s at 50 MHz).
- REPEAT_CYCLES, 10_000_000: cycles between subsequent auto-repeats.
- COOLDOWN_CYCLES, 4: idle cycles forced after each accepted command; 0 = no cooldown.
- CNT_W, 25: width of the hold/repeat and cooldown counters; must hold max(HOLD_CYCLES, REPEAT_CYCLES, COOLDOWN_CYCLES).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- key_pos  in  4  one-cycle press pulses; bit0 up, bit1 down, bit2 left, bit3 right.
- key_level  in  4  debounced key levels, same bit order.
- restart_pos  in  1  one-cycle restart press pulse.
- cmd_ready  in  1  engine can accept a command.
- cmd_valid  out  1  command offered.
- cmd_code  out  3  0 up, 1 down, 2 left, 3 right, 4 restart.
- busy  out  1  high when state ≠ IDLE or the pending slot is full.
- drop_cnt  out  8  saturating count of discarded direction events.

## Operation
- Reset values:
  - outputs: cmd_valid=0, cmd_code=0, busy=0, drop_cnt=0;
  - internal: state IDLE, pending slot empty, rr_ptr=0, repeat timer idle.
- Event sources, evaluated each cycle:
  - restart_pos;
  - key_pos;
  - a synthetic repeat event for rep_dir (see below).
- Event priority in one cycle:
  - restart over any direction;
  - real presses over the synthetic repeat.
- Round-robin among multiple key_pos bits: grant the first set bit searching upward mod 4 from rr_ptr. Afterwards rr_ptr = granted+1. rr_ptr updates only for real presses.
- States:
  - IDLE: a winning event → load cmd_code, cmd_valid=1, go ISSUE.
  - ISSUE: cmd_valid and cmd_code held stable until cmd_valid&&cmd_ready (never withdrawn). On accept, go COOLDOWN with counter=COOLDOWN_CYCLES. If COOLDOWN_CYCLES=0, go directly to the next-state rule below.
  - COOLDOWN: cmd_valid=0, counter decrements each cycle. On reaching 0, apply the next-state rule.
  - Next-state rule: if the pending slot is full → ISSUE with the pending code, slot cleared. Else → IDLE.
- Pending slot (one entry), used for events arriving in ISSUE or COOLDOWN:
  - slot empty: store the event;
  - slot full, new direction: drop it, drop_cnt+1, saturating at 255;
  - slot full, new restart: overwrite the slot with restart. The overwritten direction counts as a drop.
- An accept cycle with a simultaneous new event: the event goes to the pending slot.
- Restart, on issue: clears the repeat timer.
- Auto-repeat:
  - a real direction grant sets rep_dir and loads the timer with HOLD_CYCLES;
  - the timer decrements while key_level[rep_dir]=1 and no other key_level bit is set;
  - any other condition idles the timer;
  - at 1→0 it emits one synthetic event for rep_dir and reloads REPEAT_CYCLES.

## Timing
- key_pos pulse in cycle t with state IDLE → cmd_valid=1 at t+1 (1-cycle latency).
- Accept at cycle a → cmd_valid=0 for cycles a+1 … a+COOLDOWN_CYCLES.
- A pending command is valid at a+COOLDOWN_CYCLES+1; at a+1 when COOLDOWN_CYCLES=0.
- First repeat event occurs HOLD_CYCLES cycles after the grant cycle; subsequent ones every REPEAT_CYCLES while held.
- Asynchronous reset mid-ISSUE: cmd_valid drops immediately; the pending command and drop_cnt are lost.
- Back-to-back throughput: one command per 1+COOLDOWN_CYCLES cycles, with cmd_ready held high.

## Structure
- Package game_cmd_pkg:
  - cmd code constants CMD_UP=0, CMD_DOWN=1, CMD_LEFT=2, CMD_RIGHT=3, CMD_RESTART=4;
  - state encoding IDLE/ISSUE/COOLDOWN;
  - key bit-order constants.
- Sub-module rr_arbiter4: 4-bit request, 2-bit pointer in; one-hot grant and valid out. Purely combinational; the pointer register lives in the parent.
- Hold/repeat timer and cooldown counter stay in the parent.

## Test plan
- After reset, pulse key_pos=4'b0100, cmd_ready=1 → cmd_valid at next cycle with cmd_code=2; COOLDOWN_CYCLES=4 → valid low for 4 cycles.
- key_pos=4'b1111 three times, spaced past cooldown, rr_ptr=0 → codes 0, 1, 2 in order.
- cmd_ready=0 while valid: press up, then down, then left → cmd_code stays 0; pending=down; drop_cnt=1. Raise cmd_ready → up then down issued; drop_cnt remains 1.
- Direction pending while ISSUE is blocked, then restart_pos → pending becomes code 4, drop_cnt+1. Restart is issued after the current command.
- HOLD_CYCLES=10, REPEAT_CYCLES=5: press and hold right for 30 cycles → synthetic commands code 3 at grant+10, +15, +20, +25. Pressing a second key stops the repeats.
- Assert reset while cmd_valid=1 and pending full → all outputs 0 immediately; no command issued after reset release.
